// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between the instruction and data caches, with a grant
// timeout and a sticky fault flag. Define ARB_RR_EN for round-robin on simultaneous requests.
module mem_arbiter #(
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned ADDR_W         = 32,
  localparam int unsigned DATA_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err_n;
  logic             d_req;
  logic             pick_d;
  logic             req_held;

  assign iload = ramload;
  assign dload = ramload;
  assign d_req = dREN | dWEN;

`ifdef ARB_RR_EN
  logic last_d, last_d_n;

  // Remembers which cache held the previous grant (0 = instruction).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_d <= 1'b0;
    else     last_d <= last_d_n;
  end

  assign last_d_n = (state == IDLE && state_n == GNT_D) ? 1'b1 :
                    (state == IDLE && state_n == GNT_I) ? 1'b0 : last_d;
  assign pick_d   = d_req && !(iREN && last_d);
`else
  assign pick_d   = d_req;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  // Grant selection, RAM drive and transaction termination.
  always_comb begin
    state_n  = state;
    cnt_n    = '0;
    err_n    = err;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    req_held = 1'b0;

    case (state)
      IDLE: begin
        if (pick_d)    state_n = GNT_D;
        else if (iREN) state_n = GNT_I;
      end
      GNT_I: begin
        ramREN   = iREN;
        ramaddr  = iaddr;
        iwait    = (ramstate != RS_ACCESS);
        req_held = iREN;
      end
      GNT_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = (ramstate != RS_ACCESS);
        req_held = d_req;
      end
      default: state_n = IDLE;
    endcase

    // A dropped request or completed access ends quietly; faults and timeouts flag err.
    if (state != IDLE) begin
      if (!req_held || ramstate == RS_ACCESS) begin
        state_n = IDLE;
      end else if (ramstate == RS_ERROR || cnt == CNT_LAST) begin
        state_n = IDLE;
        err_n   = 1'b1;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL give the number of granted cycles without ACCESS before the block aborts.
REQ-003 Port CLK  in  1  SHALL be the single clock, with all state updated on the rising edge.
REQ-004 Port RST  in  1  SHALL be the asynchronous active-high reset.
REQ-005 Ports iREN in 1 and iaddr in 32 SHALL carry the instruction-cache read request and its word address.
REQ-006 Ports iwait out 1 and iload out 32 SHALL carry the instruction stall and the instruction read data.
REQ-007 Ports dREN in 1, dWEN in 1, daddr in 32 and dstore in 32 SHALL carry the data-cache read/write request, address and write data.
REQ-008 Ports dwait out 1 and dload out 32 SHALL carry the data stall and the data read data.
REQ-009 Ports ramREN out 1, ramWEN out 1, ramaddr out 32 and ramstore out 32 SHALL drive the single RAM port.
REQ-010 Ports ramload in 32 and ramstate in 2 SHALL carry RAM read data and RAM status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
REQ-011 Port err out 1 SHALL be a sticky fault flag.

Function
REQ-012 The FSM SHALL have states IDLE, GNT_I and GNT_D; the grant SHALL be registered, so the first RAM drive is 1 cycle after a request is seen in IDLE.
REQ-013 In IDLE, with only iREN high, next state SHALL be GNT_I; with only dREN or dWEN high, GNT_D; with none, IDLE.
REQ-014 In IDLE, with both caches requesting, the data cache SHALL win (fixed priority, unless REQ-028 applies).
REQ-015 In GNT_I: ramREN=iREN, ramWEN=0, ramaddr=iaddr; in GNT_D: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore; in IDLE all RAM outputs SHALL be 0.
REQ-016 When dREN and dWEN are both high, the block SHALL perform a write.
REQ-017 iwait SHALL be 0 only in GNT_I with ramstate==ACCESS; dwait SHALL be 0 only in GNT_D with ramstate==ACCESS; otherwise both SHALL be 1 (combinational).
REQ-018 iload and dload SHALL equal ramload combinationally at all times.
REQ-019 On ACCESS in a grant state, next state SHALL be IDLE, giving one cycle of turnaround between transactions.
REQ-020 If the granted requester drops its enable(s) before ACCESS, the RAM enables SHALL fall in that same cycle, and next state SHALL be IDLE with no error.
REQ-021 A 5-bit timeout counter SHALL clear on entering a grant state and increment each granted cycle without ACCESS.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 without ACCESS, err SHALL set, the wait output SHALL stay 1, and next state SHALL be IDLE.
REQ-023 ramstate==ERROR in a grant state SHALL set err, keep the wait output at 1, and force next state to IDLE; the requester retries.
REQ-024 err SHALL remain set until reset.
REQ-025 ramstate FREE or BUSY SHALL only hold the current grant state.

Reset
REQ-026 While RST is high: state=IDLE, counter=0, err=0, last-grant=I; hence ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately (asynchronously), with no RAM write enable active after assertion.

Configuration
REQ-028 With macro ARB_RR_EN defined, a registered last-grant bit SHALL be kept, and on simultaneous requests in IDLE the requester not granted last SHALL win.
REQ-029 Without ARB_RR_EN, the last-grant bit SHALL not exist and the data cache SHALL always win.

Verification
REQ-030 iREN=1, iaddr=0x40, ramstate=ACCESS on cycle 2 -> GNT_I on cycle 1, ramaddr=0x40, iwait=0 and iload=ramload on cycle 2, IDLE on cycle 3.
REQ-031 iREN=1 and dWEN=1 together, daddr=0x80, dstore=0xDEADBEEF -> GNT_D, ramWEN=1, ramstore=0xDEADBEEF, iwait=1 until the data access completes, then GNT_I follows.
REQ-032 ARB_RR_EN defined, both caches requesting continuously -> grants alternate D,I,D,I; without the macro -> D,D,D.
REQ-033 Granted, ramstate held BUSY for 16 cycles -> err=1 on cycle 16, wait still 1, state IDLE.
REQ-034 Granted and ramstate=ERROR -> err=1 sticky, wait 1, return to IDLE; RST pulse -> err=0.
REQ-035 dREN drops while GNT_D and BUSY -> ramREN=0 in the same cycle, IDLE next, err=0.
